btn_cond: RTL and testbench

- Multi-channel push-button conditioner, parametrised in channel count and timing.
- Per channel:
  - 2-flop synchroniser.
  - Counter-based debouncer.
  - One-cycle press and release pulses.
  - Optional press-and-hold auto-repeat pulses.
- Sits between raw board switch/button pins and the control FSMs.
- Replaces the single-channel, undebounced rising-edge detector.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_cond_ch.sv | 128 ++++++++++++
 rtl/btn_cond.sv | 37 +++
 tb/tb_btn_cond.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and sizing helpers for the button conditioner
package btn_pkg;

  // Repeat FSM encoding; the fourth code point is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } rpt_state_t;

  // Width of a counter that must hold values 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// rtl/btn_cond_ch.sv - one button channel: synchroniser, debouncer, edge pulses, auto-repeat
module btn_cond_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = 20,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10,
  parameter int EN_REPEAT     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DW = cnt_width(DB_CYCLES);
  localparam int HW = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;
  logic          level_nxt;
  logic          press_nxt;
  logic          rel_nxt;
  logic          rpt_nxt;
  logic          rise;
  logic          fall;
  rpt_state_t    state;
  rpt_state_t    state_nxt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      dcnt  <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      s1    <= sw;
      s2    <= s1;
      dcnt  <= dcnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
      rpt   <= rpt_nxt;
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Debounce: a level change is accepted only after DB_CYCLES unbroken disagreeing samples.
  always_comb begin
    dcnt_nxt  = dcnt;
    level_nxt = level;
    rise      = 1'b0;
    fall      = 1'b0;
    if (s2 == level) begin
      dcnt_nxt = '0;
    end else if (dcnt == DB_LAST) begin
      dcnt_nxt  = '0;
      level_nxt = s2;
      rise      = s2;
      fall      = ~s2;
    end else begin
      dcnt_nxt = dcnt + 1'b1;
    end
  end

  // Repeat FSM; an accepted fall pre-empts every state, so release beats a repeat expiry.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    rpt_nxt   = 1'b0;
    press_nxt = rise;
    rel_nxt   = fall;
    if (fall) begin
      state_nxt = IDLE;
      hcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = HOLD;
            hcnt_nxt  = '0;
          end
        end
        HOLD: begin
          if (EN_REPEAT != 0) begin
            if (hcnt == HOLD_LAST) begin
              rpt_nxt   = 1'b1;
              hcnt_nxt  = '0;
              state_nxt = REPEAT;
            end else begin
              hcnt_nxt = hcnt + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (hcnt == RPT_LAST) begin
            rpt_nxt  = 1'b1;
            hcnt_nxt = '0;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - multi-channel push-button conditioner, one independent channel per button
module btn_cond
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 20,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10,
  parameter int EN_REPEAT     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] sw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] rpt
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_cond_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .EN_REPEAT    (EN_REPEAT)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .sw   (sw[i]),
      .level(level[i]),
      .press(press[i]),
      .rel  (rel[i]),
      .rpt  (rpt[i])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// tb/tb_btn_cond.sv - directed self-checking bench for btn_cond
module tb_btn_cond;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] rpt;

  int tests = 0;
  int fails = 0;

  btn_cond #(
    .N_BTN(4), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .EN_REPEAT(1)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .level(level), .press(press), .rel(rel), .rpt(rpt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each tick crosses one rising edge and returns on the following falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic act;

  initial begin
    reset = 1'b1;
    sw    = 4'b0000;
    @(negedge clk);
    check("rst_level", 32'(level), 32'h0);
    check("rst_press", 32'(press), 32'h0);
    check("rst_rel",   32'(rel),   32'h0);
    check("rst_rpt",   32'(rpt),   32'h0);
    reset = 1'b0;
    tick(3);
    check("idle_level", 32'(level), 32'h0);

    // Clean press on channel 0
    sw[0] = 1'b1;
    tick(5);
    check("cp_level_e4", 32'(level), 32'h0);
    check("cp_press_e4", 32'(press), 32'h0);
    tick(1);
    check("cp_level_e5", 32'(level), 32'h1);
    check("cp_press_e5", 32'(press), 32'h1);
    check("cp_rel_e5",   32'(rel),   32'h0);
    tick(1);
    check("cp_press_e6", 32'(press), 32'h0);
    check("cp_level_e6", 32'(level), 32'h1);
    sw[0] = 1'b0;
    tick(6);
    check("cp_rel_fall",   32'(rel),   32'h1);
    check("cp_level_fall", 32'(level), 32'h0);
    check("cp_rpt_fall",   32'(rpt),   32'h0);
    tick(1);
    check("cp_rel_done", 32'(rel), 32'h0);

    // Bounce on channel 1: three high samples then one low, five times
    act = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sw[1] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        act = act | level[1] | press[1] | rel[1];
      end
      sw[1] = 1'b0;
      tick(1);
      act = act | level[1] | press[1] | rel[1];
    end
    for (int j = 0; j < 6; j++) begin
      tick(1);
      act = act | level[1] | press[1] | rel[1];
    end
    check("bounce_activity", 32'(act), 32'h0);

    // Hold and auto-repeat on channel 2
    sw[2] = 1'b1;
    tick(6);
    check("hold_press", 32'(press), 32'h4);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      check($sformatf("hold_rpt_p%0d", k), 32'(rpt[2]),
            32'((k == 10 || k == 13 || k == 16) ? 1 : 0));
    end
    // Fall accepted at P+22, which is also a repeat expiry edge
    sw[2] = 1'b0;
    tick(2);
    check("rr_rpt_p18", 32'(rpt[2]), 32'h0);
    tick(1);
    check("rr_rpt_p19", 32'(rpt[2]), 32'h1);
    tick(2);
    check("rr_rpt_p21", 32'(rpt[2]), 32'h0);
    check("rr_rel_p21", 32'(rel[2]), 32'h0);
    tick(1);
    check("rr_rel_p22",   32'(rel[2]),   32'h1);
    check("rr_rpt_p22",   32'(rpt[2]),   32'h0);
    check("rr_level_p22", 32'(level[2]), 32'h0);
    check("rr_state_p22", 32'(dut.g_ch[2].u_ch.state), 32'(IDLE));
    act = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      act = act | rpt[2] | rel[2];
    end
    check("rr_quiet_after", 32'(act), 32'h0);

    // All four channels together
    sw = 4'b1111;
    tick(5);
    check("all_press_e4", 32'(press), 32'h0);
    tick(1);
    check("all_press_e5", 32'(press), 32'hf);
    check("all_level_e5", 32'(level), 32'hf);
    tick(1);
    check("all_press_e6", 32'(press), 32'h0);
    sw = 4'b0000;
    tick(5);
    check("all_rel_e4", 32'(rel), 32'h0);
    tick(1);
    check("all_rel_e5",   32'(rel),   32'hf);
    check("all_press_rl", 32'(press), 32'h0);
    check("all_level_rl", 32'(level), 32'h0);
    tick(1);
    check("all_rel_e6", 32'(rel), 32'h0);

    // Reset while channel 3 is auto-repeating
    sw[3] = 1'b1;
    tick(6);
    check("rh_press", 32'(press), 32'h8);
    tick(12);
    check("rh_state", 32'(dut.g_ch[3].u_ch.state), 32'(REPEAT));
    reset = 1'b1;
    #1;
    check("rh_level_async", 32'(level), 32'h0);
    check("rh_any_async",   32'(press | rel | rpt), 32'h0);
    @(negedge clk);
    tick(2);
    check("rh_rel_in_rst", 32'(rel), 32'h0);
    reset = 1'b0;
    tick(5);
    check("rh_level_e4", 32'(level), 32'h0);
    check("rh_rel_e4",   32'(rel),   32'h0);
    tick(1);
    check("rh_press_e5", 32'(press), 32'h8);
    check("rh_level_e5", 32'(level), 32'h8);
    tick(1);
    check("rh_press_e6", 32'(press), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
